// File: rtl/pci_master_sched.sv
// Splits write/read commands into PCI segments bounded by MAX_BURST and the
// cacheline boundary, arbitrating round-robin between the two command paths.
module pci_master_sched #(
    parameter int MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  wcmd_id,
    input  logic [7:0]  wcmd_len,
    input  logic [63:0] wcmd_addr,
    input  logic        wcmd_valid,
    output logic        wcmd_ready,
    input  logic [3:0]  rcmd_id,
    input  logic [7:0]  rcmd_len,
    input  logic [63:0] rcmd_addr,
    input  logic        rcmd_valid,
    output logic        rcmd_ready,
    input  logic [7:0]  cacheline_size,
    output logic        seg_wrdn,
    output logic [3:0]  seg_id,
    output logic [63:0] seg_addr,
    output logic [7:0]  seg_len,
    output logic        seg_last,
    output logic        seg_valid,
    input  logic        seg_ready,
    input  logic        seg_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [8:0] MAX_BURST_W = 9'(MAX_BURST);

    state_t      r_state, w_state_nxt;
    logic        r_last_w, w_last_w_nxt;
    logic        r_wrdn, w_wrdn_nxt;
    logic [3:0]  r_id, w_id_nxt;
    logic [63:0] r_addr, w_addr_nxt;
    logic [8:0]  r_rem, w_rem_nxt;
    logic [7:0]  r_cls, w_cls_nxt;
    logic [7:0]  r_seg_len, w_seg_len_nxt;
    logic        r_seg_last, w_seg_last_nxt;
    logic        w_wgrant, w_rgrant;
    logic [8:0]  w_n_cur, w_n_nxt;

    // Beats of the next segment: min(remaining, MAX_BURST, beats to cacheline boundary)
    function automatic logic [8:0] seg_beats(input logic [8:0] rem,
                                             input logic [7:0] dw_off,
                                             input logic [7:0] cls);
        logic       usable;
        logic [8:0] bnd;
        logic [8:0] n;
        usable = (cls != 8'd0) && ((cls & (cls - 8'd1)) == 8'd0);
        bnd    = {1'b0, cls} - {1'b0, dw_off & (cls - 8'd1)};
        n      = (rem < MAX_BURST_W) ? rem : MAX_BURST_W;
        n      = (usable && (bnd < n)) ? bnd : n;
        return n;
    endfunction

    assign w_n_cur    = {1'b0, r_seg_len} + 9'd1;
    assign wcmd_ready = w_wgrant && !rst;
    assign rcmd_ready = w_rgrant && !rst;
    assign seg_valid  = (r_state == S_ISSUE);
    assign busy       = (r_state != S_IDLE);
    assign seg_wrdn   = r_wrdn;
    assign seg_id     = r_id;
    assign seg_addr   = r_addr;
    assign seg_len    = r_seg_len;
    assign seg_last   = r_seg_last;

    // Next-state, arbitration and segment computation
    always_comb begin
        w_state_nxt    = r_state;
        w_last_w_nxt   = r_last_w;
        w_wrdn_nxt     = r_wrdn;
        w_id_nxt       = r_id;
        w_addr_nxt     = r_addr;
        w_rem_nxt      = r_rem;
        w_cls_nxt      = r_cls;
        w_seg_len_nxt  = r_seg_len;
        w_seg_last_nxt = r_seg_last;
        w_wgrant       = 1'b0;
        w_rgrant       = 1'b0;
        w_n_nxt        = 9'd0;
        case (r_state)
            S_IDLE: begin
                // Write wins unless read is also pending and write was granted last
                if (wcmd_valid && (!rcmd_valid || !r_last_w)) begin
                    w_wgrant = 1'b1;
                end else if (rcmd_valid) begin
                    w_rgrant = 1'b1;
                end else begin
                    w_wgrant = 1'b0;
                end
                if (w_wgrant || w_rgrant) begin
                    w_state_nxt    = S_ISSUE;
                    w_last_w_nxt   = w_wgrant;
                    w_wrdn_nxt     = w_wgrant;
                    w_id_nxt       = w_wgrant ? wcmd_id : rcmd_id;
                    w_addr_nxt     = w_wgrant ? wcmd_addr : rcmd_addr;
                    w_rem_nxt      = {1'b0, (w_wgrant ? wcmd_len : rcmd_len)} + 9'd1;
                    w_cls_nxt      = cacheline_size;
                    w_n_nxt        = seg_beats(w_rem_nxt, w_addr_nxt[9:2], w_cls_nxt);
                    w_seg_len_nxt  = w_n_nxt[7:0] - 8'd1;
                    w_seg_last_nxt = (w_n_nxt == w_rem_nxt);
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (seg_ready) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (seg_done) begin
                    w_addr_nxt     = r_addr + {53'd0, w_n_cur, 2'b00};
                    w_rem_nxt      = r_rem - w_n_cur;
                    w_n_nxt        = seg_beats(w_rem_nxt, w_addr_nxt[9:2], r_cls);
                    w_seg_len_nxt  = w_n_nxt[7:0] - 8'd1;
                    w_seg_last_nxt = (w_n_nxt == w_rem_nxt);
                    w_state_nxt    = (w_rem_nxt != 9'd0) ? S_ISSUE : S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and command registers; reset leaves the pointer at "read last"
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_last_w   <= 1'b0;
            r_wrdn     <= 1'b0;
            r_id       <= 4'd0;
            r_addr     <= 64'd0;
            r_rem      <= 9'd0;
            r_cls      <= 8'd0;
            r_seg_len  <= 8'd0;
            r_seg_last <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_w   <= w_last_w_nxt;
            r_wrdn     <= w_wrdn_nxt;
            r_id       <= w_id_nxt;
            r_addr     <= w_addr_nxt;
            r_rem      <= w_rem_nxt;
            r_cls      <= w_cls_nxt;
            r_seg_len  <= w_seg_len_nxt;
            r_seg_last <= w_seg_last_nxt;
        end
    end

endmodule

// File: tb/tb_pci_master_sched.sv
// Directed bench for pci_master_sched: hand-computed segment splits,
// arbitration order, handshake corner cases and mid-command reset.
module tb_pci_master_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wcmd_id, rcmd_id;
    logic [7:0]  wcmd_len, rcmd_len;
    logic [63:0] wcmd_addr, rcmd_addr;
    logic        wcmd_valid, rcmd_valid, wcmd_ready, rcmd_ready;
    logic [7:0]  cacheline_size;
    logic        seg_wrdn, seg_last, seg_valid, seg_ready, seg_done, busy;
    logic [3:0]  seg_id;
    logic [63:0] seg_addr;
    logic [7:0]  seg_len;

    int vectors = 0;
    int miscompares = 0;

    pci_master_sched #(.MAX_BURST(16)) dut (
        .clk(clk), .rst(rst),
        .wcmd_id(wcmd_id), .wcmd_len(wcmd_len), .wcmd_addr(wcmd_addr),
        .wcmd_valid(wcmd_valid), .wcmd_ready(wcmd_ready),
        .rcmd_id(rcmd_id), .rcmd_len(rcmd_len), .rcmd_addr(rcmd_addr),
        .rcmd_valid(rcmd_valid), .rcmd_ready(rcmd_ready),
        .cacheline_size(cacheline_size),
        .seg_wrdn(seg_wrdn), .seg_id(seg_id), .seg_addr(seg_addr),
        .seg_len(seg_len), .seg_last(seg_last),
        .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_done(seg_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait (bounded) for the expected ready, check exclusivity, then step past acceptance
    task automatic accept(input logic is_w);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (is_w ? wcmd_ready : rcmd_ready) break;
            cyc();
        end
        chk(is_w ? "wcmd_ready" : "rcmd_ready", is_w ? wcmd_ready : rcmd_ready, 1'b1);
        chk("other_ready_low", is_w ? rcmd_ready : wcmd_ready, 1'b0);
        cyc();
        chk("first_seg_latency", seg_valid, 1'b1);
        chk("ready_outside_idle", wcmd_ready | rcmd_ready, 1'b0);
    endtask

    task automatic serve_seg(input logic [63:0] a, input logic [7:0] l, input logic last,
                             input logic wrdn, input logic [3:0] id);
        for (int i = 0; i < 20; i++) begin
            if (seg_valid) break;
            cyc();
        end
        chk("seg_valid", seg_valid, 1'b1);
        chk("seg_addr", seg_addr, a);
        chk("seg_len", seg_len, l);
        chk("seg_last", seg_last, last);
        chk("seg_wrdn", seg_wrdn, wrdn);
        chk("seg_id", seg_id, id);
        seg_ready = 1'b1;
        cyc();
        seg_ready = 1'b0;
        chk("wait_no_valid", seg_valid, 1'b0);
        chk("wait_busy", busy, 1'b1);
        seg_done = 1'b1;
        cyc();
        seg_done = 1'b0;
        if (last) chk("idle_after_last", busy, 1'b0);
        else      chk("next_seg_latency", seg_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; seg_ready = 1'b0; seg_done = 1'b0;
        wcmd_valid = 1'b0; rcmd_valid = 1'b0;
        wcmd_id = 4'd0; wcmd_len = 8'd0; wcmd_addr = 64'd0;
        rcmd_id = 4'd0; rcmd_len = 8'd0; rcmd_addr = 64'd0;
        cacheline_size = 8'd16;
        @(negedge clk);
        cyc();
        cyc();
        chk("rst_seg_valid", seg_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_seg_addr", seg_addr, 64'd0);
        chk("rst_seg_len", seg_len, 8'd0);
        chk("rst_seg_last", seg_last, 1'b0);
        chk("rst_seg_wrdn", seg_wrdn, 1'b0);
        chk("rst_seg_id", seg_id, 4'd0);
        rst = 1'b0;

        // Single-segment write
        wcmd_id = 4'd3; wcmd_len = 8'd3; wcmd_addr = 64'h1000; wcmd_valid = 1'b1;
        accept(1'b1);
        wcmd_valid = 1'b0;
        serve_seg(64'h1000, 8'd3, 1'b1, 1'b1, 4'd3);

        // Read split at cacheline boundary; cls change after acceptance has no effect
        rcmd_id = 4'd4; rcmd_len = 8'd9; rcmd_addr = 64'h1038; rcmd_valid = 1'b1;
        accept(1'b0);
        rcmd_valid = 1'b0;
        cacheline_size = 8'd4;
        serve_seg(64'h1038, 8'd1, 1'b0, 1'b0, 4'd4);
        serve_seg(64'h1040, 8'd7, 1'b1, 1'b0, 4'd4);

        // Max-burst split with cls 0
        cacheline_size = 8'd0;
        wcmd_id = 4'd5; wcmd_len = 8'd39; wcmd_addr = 64'h0; wcmd_valid = 1'b1;
        accept(1'b1);
        wcmd_valid = 1'b0;
        serve_seg(64'h0,  8'd15, 1'b0, 1'b1, 4'd5);
        serve_seg(64'h40, 8'd15, 1'b0, 1'b1, 4'd5);
        serve_seg(64'h80, 8'd7,  1'b1, 1'b1, 4'd5);

        // Non power-of-two cls, stalled seg_ready, seg_done during ISSUE
        cacheline_size = 8'd12;
        rcmd_id = 4'd9; rcmd_len = 8'd9; rcmd_addr = 64'h1038; rcmd_valid = 1'b1;
        accept(1'b0);
        rcmd_valid = 1'b0;
        cacheline_size = 8'd16;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", seg_valid, 1'b1);
            chk("hold_len", seg_len, 8'd9);
            chk("hold_addr", seg_addr, 64'h1038);
            chk("hold_last", seg_last, 1'b1);
            seg_done = (i == 2);
            cyc();
        end
        seg_done = 1'b0;
        chk("done_in_issue_ignored", seg_valid, 1'b1);
        seg_ready = 1'b1; seg_done = 1'b1;
        cyc();
        seg_ready = 1'b0; seg_done = 1'b0;
        chk("ready_done_wait_valid", seg_valid, 1'b0);
        chk("ready_done_wait_busy", busy, 1'b1);
        seg_done = 1'b1;
        cyc();
        seg_done = 1'b0;
        chk("hold_cmd_done", busy, 1'b0);

        // Round-robin with both paths holding two commands
        wcmd_id = 4'd1; wcmd_len = 8'd0; wcmd_addr = 64'h100; wcmd_valid = 1'b1;
        rcmd_id = 4'd2; rcmd_len = 8'd1; rcmd_addr = 64'h200; rcmd_valid = 1'b1;
        accept(1'b1);
        wcmd_id = 4'd3; wcmd_len = 8'd2; wcmd_addr = 64'h300;
        serve_seg(64'h100, 8'd0, 1'b1, 1'b1, 4'd1);
        accept(1'b0);
        rcmd_id = 4'd4; rcmd_len = 8'd3; rcmd_addr = 64'h400;
        serve_seg(64'h200, 8'd1, 1'b1, 1'b0, 4'd2);
        accept(1'b1);
        wcmd_valid = 1'b0;
        serve_seg(64'h300, 8'd2, 1'b1, 1'b1, 4'd3);
        accept(1'b0);
        rcmd_valid = 1'b0;
        serve_seg(64'h400, 8'd3, 1'b1, 1'b0, 4'd4);

        // Reset while in WAIT after a write grant; write must still win afterwards
        wcmd_id = 4'd6; wcmd_len = 8'd0; wcmd_addr = 64'h2000; wcmd_valid = 1'b1;
        accept(1'b1);
        wcmd_valid = 1'b0;
        seg_ready = 1'b1;
        cyc();
        seg_ready = 1'b0;
        chk("pre_rst_in_wait", busy, 1'b1);
        rst = 1'b1;
        wcmd_id = 4'd7; wcmd_len = 8'd1; wcmd_addr = 64'h3000; wcmd_valid = 1'b1;
        rcmd_id = 4'd8; rcmd_len = 8'd0; rcmd_addr = 64'h4000; rcmd_valid = 1'b1;
        cyc();
        #1;
        chk("rst_mid_seg_valid", seg_valid, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_seg_addr", seg_addr, 64'd0);
        chk("rst_mid_no_ready", wcmd_ready | rcmd_ready, 1'b0);
        rst = 1'b0;
        accept(1'b1);
        wcmd_valid = 1'b0;
        serve_seg(64'h3000, 8'd1, 1'b1, 1'b1, 4'd7);
        accept(1'b0);
        rcmd_valid = 1'b0;
        serve_seg(64'h4000, 8'd0, 1'b1, 1'b0, 4'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
